// File: rtl/stream_rr_arbiter.sv
// Round-robin, packet-locked arbiter feeding one registered valid/ready stage.
// Grant is combinational in IDLE and pinned to the packet owner while LOCKED.
module stream_rr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [SRC_W-1:0]              out_src,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [SRC_W-1:0]        last_grant_q, last_grant_d;
  logic [SRC_W-1:0]        lock_idx_q, lock_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [SRC_W-1:0]        out_src_q, out_src_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

  logic                    stage_ready_s;
  logic                    found_s;
  logic [SRC_W-1:0]        grant_s;
  logic [SRC_W-1:0]        scan_idx_s;
  logic [SRC_W-1:0]        sel_s;
  logic                    sel_en_s;
  logic                    sel_valid_s;
  logic                    sel_last_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic                    accept_s;
  logic [NUM_REQ-1:0]      req_ready_s;

  assign stage_ready_s = ~out_valid_q | out_ready;

  // Round-robin scan starting one past the last completed packet's owner
  always_comb begin
    grant_s    = '0;
    found_s    = 1'b0;
    scan_idx_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx_s = SRC_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found_s && req_valid[scan_idx_s]) begin
        found_s = 1'b1;
        grant_s = scan_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Selected source: packet owner while locked, scan winner otherwise
  always_comb begin
    sel_s       = (state_q == LOCKED) ? lock_idx_q : grant_s;
    sel_en_s    = (state_q == LOCKED) | found_s;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    req_ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (SRC_W'(i) == sel_s) begin
        sel_valid_s    = req_valid[i];
        sel_last_s     = req_last[i];
        sel_data_s     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready_s[i] = ~rst & sel_en_s & stage_ready_s;
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
    accept_s = ~rst & sel_en_s & stage_ready_s & sel_valid_s;
  end

  // Packet lock FSM; the pointer only moves when a packet's last beat is taken
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_idx_d   = lock_idx_q;
    case (state_q)
      IDLE: begin
        if (accept_s && sel_last_s) begin
          last_grant_d = sel_s;
        end else if (accept_s) begin
          state_d    = LOCKED;
          lock_idx_d = sel_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (accept_s && sel_last_s) begin
          state_d      = IDLE;
          last_grant_d = lock_idx_q;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output stage: load on accept, otherwise empty on drain, payload holds
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    out_data_d  = out_data_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_last_d  = sel_last_s;
      out_src_d   = sel_s;
      out_data_d  = sel_data_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      lock_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_src_q    <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_idx_q   <= lock_idx_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_src_q    <= out_src_d;
      out_data_q   <= out_data_d;
    end
  end

  assign req_ready = req_ready_s;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomised and directed checks of stream_rr_arbiter against a queue-level
// model: owner/next-priority pointer plus a one-entry output slot.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [1:0]        out_src;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // requester-side stimulus
  logic [DW-1:0] dat [N];
  logic [N-1:0]  vld;
  logic [N-1:0]  lst;

  // model: packet owner (-1 none), next priority index, output slot
  int            m_owner;
  int            m_next;
  logic          m_sv;
  logic [DW-1:0] m_sd;
  logic          m_sl;
  int            m_ss;

  int total;
  int bad;
  int last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_next  = 0;
    m_sv    = 1'b0;
    m_sd    = '0;
    m_sl    = 1'b0;
    m_ss    = 0;
  endtask

  function automatic int m_cand();
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (vld[(m_next + k) % N]) return (m_next + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int c;
    r = '0;
    c = m_cand();
    if (!rst && c >= 0) r[c] = !m_sv || out_ready;
    return r;
  endfunction

  task automatic apply();
    req_valid = vld;
    req_last  = lst;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
  endtask

  task automatic compare();
    chk("req_ready", 32'(req_ready), 32'(m_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_sv));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    if (m_sv) begin
      chk("out_data", out_data, m_sd);
      chk("out_last", 32'(out_last), 32'(m_sl));
      chk("out_src", 32'(out_src), 32'(m_ss));
    end
  endtask

  task automatic step();
    int c;
    logic sp;
    last_acc = -1;
    if (rst) begin
      m_reset();
      return;
    end
    c  = m_cand();
    sp = !m_sv || out_ready;
    if (c >= 0 && sp && vld[c]) begin
      last_acc = c;
      m_sv = 1'b1; m_sd = dat[c]; m_sl = lst[c]; m_ss = c;
      if (lst[c]) begin
        m_owner = -1;
        m_next  = (c + 1) % N;
      end else begin
        m_owner = c;
      end
    end else if (m_sv && out_ready) begin
      m_sv = 1'b0;
    end
  endtask

  // one cycle: drive at negedge, compare, advance model at posedge
  task automatic tick();
    apply();
    #1 compare();
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    vld = '0; lst = '0;
    apply();
    #1 compare();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_beat(input int i);
    vld[i] = 1'b1;
    dat[i] = $urandom;
    lst[i] = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    total = 0; bad = 0; last_acc = -1;
    rst = 1'b1; out_ready = 1'b0;
    vld = '0; lst = '0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    m_reset();
    apply();
    @(negedge clk);

    // reset holds everything off even with all requesters valid
    vld = 4'b1111; lst = 4'b1111;
    for (int i = 0; i < N; i++) dat[i] = 32'h1000_0000 + 32'(i);
    out_ready = 1'b1;
    apply();
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // round-robin over single-beat packets, 0,1,2,3,0
    begin
      logic [1:0] exp_seq [5];
      exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
      exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
      for (int n = 0; n < 5; n++) begin
        tick();
        chk("rr_src", 32'(out_src), 32'(exp_seq[n]));
        chk("rr_valid", 32'(out_valid), 32'h1);
      end
    end

    // three-beat packet from req0 locks out req1
    do_reset();
    out_ready = 1'b1;
    vld = 4'b0011; lst = 4'b0010;
    dat[0] = 32'h0000_00B1; dat[1] = 32'h1111_0001;
    for (int b = 0; b < 3; b++) begin
      apply();
      #1 chk("lock_ready", 32'(req_ready), 32'h1);
      tick();
      chk("lock_busy", 32'(busy), (b < 2) ? 32'h1 : 32'h0);
      dat[0] = 32'h0000_00B2 + 32'(b);
      lst[0] = (b == 1);
    end
    vld[0] = 1'b0;
    tick();
    chk("lock_follow_src", 32'(out_src), 32'h1);
    chk("lock_follow_data", out_data, 32'h1111_0001);

    // backpressure holds the stage, then drain and refill together
    do_reset();
    out_ready = 1'b0;
    vld = 4'b0001; lst = 4'b0011;
    dat[0] = 32'hA5A5_0001;
    tick();
    vld = 4'b0011; dat[0] = 32'hA5A5_0002; dat[1] = 32'hA5A5_1001;
    for (int n = 0; n < 3; n++) begin
      apply();
      #1 chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_hold", out_data, 32'hA5A5_0001);
      tick();
    end
    out_ready = 1'b1;
    apply();
    #1 chk("bp_refill_ready", 32'(req_ready), 32'h2);
    tick();
    chk("bp_refill_valid", 32'(out_valid), 32'h1);
    chk("bp_refill_src", 32'(out_src), 32'h1);

    // a stalled stage never moves the pointer
    do_reset();
    out_ready = 1'b0;
    vld = 4'b0100; lst = 4'b0110;
    dat[2] = 32'hC2C2_0002; dat[1] = 32'hC1C1_0001;
    tick();
    vld[2] = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    chk("ptr_first", 32'(out_src), 32'h2);
    vld[1] = 1'b1;
    tick();
    out_ready = 1'b1;
    tick();
    chk("ptr_second", 32'(out_src), 32'h1);

    // async reset in the middle of a req3 packet
    do_reset();
    out_ready = 1'b1;
    vld = 4'b1000; lst = 4'b0001;
    dat[3] = 32'hD3D3_0001; dat[0] = 32'hD0D0_0001;
    tick();
    dat[3] = 32'hD3D3_0002;
    tick();
    vld[0] = 1'b1;
    apply();
    rst = 1'b1;
    m_reset();
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_winner", 32'(out_src), 32'h0);

    // randomised traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    last_acc = -1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        do_reset();
        last_acc = -1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      for (int i = 0; i < N; i++) begin
        if (i == last_acc) begin
          if ($urandom_range(0, 3) == 0) vld[i] = 1'b0;
          else new_beat(i);
        end else if (!vld[i] && $urandom_range(0, 2) == 0) begin
          new_beat(i);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
